ex_mdu: RTL



---
 rtl/ex_mdu_if.sv | 27 ++
 rtl/ex_mdu.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ex_mdu_if.sv
// Operand/result bundle between the EX stage and the multi-cycle M-extension unit.
// The EX stage holds the master end; ex_mdu holds the slave end.
interface ex_mdu_if #(
    parameter int XLEN = 32
);
    logic            start_in;
    logic [2:0]      op_in;
    logic [XLEN-1:0] rs1_val_in;
    logic [XLEN-1:0] rs2_val_in;
    logic [4:0]      rd_addr_in;
    logic            flush_in;
    logic            stallreq_from_ex;
    logic            done_out;
    logic            rd_out;
    logic [XLEN-1:0] rd_val_out;
    logic [4:0]      rd_addr_out;

    modport master (
        output start_in, op_in, rs1_val_in, rs2_val_in, rd_addr_in, flush_in,
        input  stallreq_from_ex, done_out, rd_out, rd_val_out, rd_addr_out
    );

    modport slave (
        input  start_in, op_in, rs1_val_in, rs2_val_in, rd_addr_in, flush_in,
        output stallreq_from_ex, done_out, rd_out, rd_val_out, rd_addr_out
    );
endinterface

// File: rtl/ex_mdu.sv
// Multi-cycle RV32M execute unit: radix-2^MUL_BITS shift-add multiplier and
// restoring radix-2 divider sharing one 2*XLEN accumulator.
module ex_mdu #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 4
) (
    input logic     clk_in,
    input logic     rst_in,
    ex_mdu_if.slave bus
);
    localparam int K  = XLEN / MUL_BITS;
    localparam int CW = $clog2(XLEN) + 1;

    if ((MUL_BITS != 1 && MUL_BITS != 2 && MUL_BITS != 4 && MUL_BITS != 8) ||
        (XLEN % MUL_BITS) != 0) begin : g_bad_params
        $error("ex_mdu: MUL_BITS must be 1, 2, 4 or 8 and divide XLEN");
    end

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    state_e            state;
    op_e               op;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              res_neg;
    logic [4:0]        rd_addr_q;
    logic              done_q;
    logic              rd_we_q;
    logic [XLEN-1:0]   rd_val_q;
    logic [4:0]        rd_addr_out_q;

    // Accept-side decode of the operation presented this cycle.
    op_e             req_op;
    logic            rs1_neg, rs2_neg, req_is_div, div_by_zero, div_ovf;
    logic [XLEN-1:0] rs1_mag, rs2_mag, fast_val;

    always_comb begin
        req_op      = op_e'(bus.op_in);
        req_is_div  = bus.op_in[2];
        rs1_neg     = (req_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && bus.rs1_val_in[XLEN-1];
        rs2_neg     = (req_op inside {OP_MULH, OP_DIV, OP_REM}) && bus.rs2_val_in[XLEN-1];
        rs1_mag     = rs1_neg ? -bus.rs1_val_in : bus.rs1_val_in;
        rs2_mag     = rs2_neg ? -bus.rs2_val_in : bus.rs2_val_in;
        div_by_zero = req_is_div && (bus.rs2_val_in == '0);
        div_ovf     = (req_op == OP_DIV || req_op == OP_REM) &&
                      (bus.rs1_val_in == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_val_in == '1);
        // op_in[1] selects the remainder among the divide encodings.
        if (div_by_zero) fast_val = bus.op_in[1] ? bus.rs1_val_in : '1;
        else             fast_val = bus.op_in[1] ? '0 : bus.rs1_val_in;
    end

    // One iteration step of each datapath, plus the sign-corrected result.
    logic [XLEN+MUL_BITS-1:0] partial, sum_hi;
    logic [2*XLEN-1:0]        mul_next, div_next, prod;
    logic [XLEN:0]            shifted;
    logic                     q_bit;
    logic [XLEN-1:0]          new_rem, div_pick, final_val;
    logic                     last_iter;

    always_comb begin
        partial   = (XLEN+MUL_BITS)'(a_mag) * (XLEN+MUL_BITS)'(b_mag[MUL_BITS-1:0]);
        sum_hi    = (XLEN+MUL_BITS)'(acc[2*XLEN-1:XLEN]) + partial;
        mul_next  = (2*XLEN)'({sum_hi, acc[XLEN-1:0]} >> MUL_BITS);
        shifted   = acc[2*XLEN-1:XLEN-1];
        q_bit     = shifted >= {1'b0, b_mag};
        new_rem   = q_bit ? XLEN'(shifted - {1'b0, b_mag}) : shifted[XLEN-1:0];
        div_next  = {new_rem, acc[XLEN-2:0], q_bit};
        prod      = res_neg ? -mul_next : mul_next;
        div_pick  = op[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
        if (state == S_MUL) final_val = (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else                final_val = res_neg ? -div_pick : div_pick;
        last_iter = (state == S_MUL) ? (cnt == CW'(K - 1)) : (cnt == CW'(XLEN - 1));
    end

    // NOTE: all state, datapath and outputs live in one clocked block using <= only,
    // so every register sees the pre-edge values of the others.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= S_IDLE;
            op            <= OP_MUL;
            cnt           <= '0;
            acc           <= '0;
            a_mag         <= '0;
            b_mag         <= '0;
            res_neg       <= 1'b0;
            rd_addr_q     <= '0;
            done_q        <= 1'b0;
            rd_we_q       <= 1'b0;
            rd_val_q      <= '0;
            rd_addr_out_q <= '0;
        end else begin
            done_q  <= 1'b0;
            rd_we_q <= 1'b0;
            unique case (state)
                S_IDLE: if (bus.start_in && !bus.flush_in) begin
                    op        <= req_op;
                    rd_addr_q <= bus.rd_addr_in;
                    cnt       <= '0;
                    a_mag     <= rs1_mag;
                    b_mag     <= rs2_mag;
                    res_neg   <= (req_op == OP_REM) ? rs1_neg : (rs1_neg ^ rs2_neg);
                    if (div_by_zero || div_ovf) begin
                        state         <= S_DONE;
                        rd_val_q      <= fast_val;
                        rd_addr_out_q <= bus.rd_addr_in;
                        done_q        <= 1'b1;
                        rd_we_q       <= (bus.rd_addr_in != 5'd0);
                    end else if (req_is_div) begin
                        state <= S_DIV;
                        acc   <= {{XLEN{1'b0}}, rs1_mag};
                    end else begin
                        state <= S_MUL;
                        acc   <= '0;
                    end
                end
                S_MUL, S_DIV: if (bus.flush_in) begin
                    state <= S_IDLE;
                end else begin
                    acc <= (state == S_MUL) ? mul_next : div_next;
                    if (state == S_MUL) b_mag <= b_mag >> MUL_BITS;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        state         <= S_DONE;
                        rd_val_q      <= final_val;
                        rd_addr_out_q <= rd_addr_q;
                        done_q        <= 1'b1;
                        rd_we_q       <= (rd_addr_q != 5'd0);
                    end
                end
                S_DONE: state <= S_IDLE;
            endcase
        end
    end

    assign bus.stallreq_from_ex = (state == S_IDLE && bus.start_in && !bus.flush_in) ||
                                  (state == S_MUL) || (state == S_DIV);
    assign bus.done_out    = done_q;
    assign bus.rd_out      = rd_we_q;
    assign bus.rd_val_out  = rd_val_q;
    assign bus.rd_addr_out = rd_addr_out_q;
endmodule
